mem_access_unit: RTL

- Initiator (MEM-stage load/store unit) for the 512x8 byte-addressable data memory.
- Accepts one load/store request from the pipeline and decodes RISC-V funct3 into memory Size/SignExtend.
- Generates the edge-triggered Enable strobe the memory requires and captures read data.
- Returns a result or an access error to the pipeline over a valid/ready handshake.

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/lsu_decode.sv | 51 +++++
 rtl/mem_access_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 codes,
// memory size codes, FSM state encoding and a size-to-byte-count helper.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        CAPTURE,
        RESP
    } state_e;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_HALF: return 3'd2;
            SZ_WORD: return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_decode.sv
// Combinational decode of funct3/store/address into memory size, sign
// extension and an access error. Defining LSU_MISALIGN_EN drops the alignment check.
module lsu_decode
    import lsu_pkg::*;
#(
    parameter int ADDR_W    = 9,
    parameter int MEM_BYTES = 512
) (
    input  logic [2:0]  i_funct3,
    input  logic        i_store,
    input  logic [31:0] i_addr,
    output logic [1:0]  o_size,
    output logic        o_sign_ext,
    output logic        o_err
);

    logic        w_legal;
    logic        w_range_err;
    logic        w_align_err;
    logic [32:0] w_last;

    // NOTE: every signal assigned in always_comb gets a default first so no path can infer a latch.
    always_comb begin
        w_legal = 1'b0;
        if (i_store) begin
            w_legal = (i_funct3 == F3_B) || (i_funct3 == F3_H) || (i_funct3 == F3_W);
        end else begin
            case (i_funct3)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: w_legal = 1'b1;
                default:                        w_legal = 1'b0;
            endcase
        end
    end

    assign o_size     = i_funct3[1:0];
    assign o_sign_ext = !i_store && !i_funct3[2] && (i_funct3[1:0] != SZ_WORD);

    // Address of the last byte touched; 33 bits so the sum cannot wrap.
    assign w_last      = {1'b0, i_addr} + 33'(size_bytes(o_size)) - 33'd1;
    assign w_range_err = (i_addr[31:ADDR_W] != '0) || (w_last >= 33'(MEM_BYTES));

`ifdef LSU_MISALIGN_EN
    assign w_align_err = 1'b0;
`else
    assign w_align_err = ((o_size == SZ_HALF) && i_addr[0]) ||
                         ((o_size == SZ_WORD) && (i_addr[1:0] != 2'b00));
`endif

    assign o_err = !w_legal || w_range_err || w_align_err;

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for the 512x8 data memory: accepts one request, strobes
// the memory on an edge-triggered enable and returns the result. Honours LSU_MISALIGN_EN.
module mem_access_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W    = 9,
    parameter int MEM_BYTES = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_data,
    output logic [4:0]        resp_rd,
    output logic              resp_err,
    output logic              mem_enable,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic [1:0]        mem_size,
    output logic              mem_sign_ext,
    input  logic [31:0]       mem_dout
);

    state_e            r_state;
    state_e            w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rw;
    logic [1:0]        r_size;
    logic              r_sign_ext;
    logic [31:0]       r_din;
    logic              r_enable;
    logic [31:0]       r_data;
    logic [4:0]        r_rd;
    logic              r_err;
    logic [1:0]        w_size;
    logic              w_sign_ext;
    logic              w_err;
    logic              w_accept;

    lsu_decode #(
        .ADDR_W    (ADDR_W),
        .MEM_BYTES (MEM_BYTES)
    ) u_decode (
        .i_funct3   (req_funct3),
        .i_store    (req_store),
        .i_addr     (req_addr),
        .o_size     (w_size),
        .o_sign_ext (w_sign_ext),
        .o_err      (w_err)
    );

    assign w_accept = (r_state == IDLE) && req_valid;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_next_state = w_err ? RESP : SETUP;
            SETUP:   w_next_state = STROBE;
            STROBE:  w_next_state = HOLD;
            HOLD:    w_next_state = CAPTURE;
            CAPTURE: w_next_state = RESP;
            RESP:    if (resp_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // The strobe is registered so it is glitch-free, and the async reset still drops it at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enable   <= 1'b0;
            r_addr     <= '0;
            r_rw       <= 1'b0;
            r_size     <= SZ_BYTE;
            r_sign_ext <= 1'b0;
            r_din      <= '0;
            r_data     <= '0;
            r_rd       <= '0;
            r_err      <= 1'b0;
        end else begin
            r_enable <= (w_next_state == STROBE) || (w_next_state == HOLD);
            if (w_accept) begin
                r_rd   <= req_rd;
                r_err  <= w_err;
                r_data <= '0;
                // Failed requests leave the memory bus untouched.
                if (!w_err) begin
                    r_addr     <= req_addr[ADDR_W-1:0];
                    r_rw       <= req_store;
                    r_size     <= w_size;
                    r_sign_ext <= w_sign_ext;
                    r_din      <= req_wdata;
                end
            end
            if ((r_state == CAPTURE) && !r_rw) r_data <= mem_dout;
        end
    end

    assign req_ready    = (r_state == IDLE);
    assign resp_valid   = (r_state == RESP);
    assign resp_data    = r_data;
    assign resp_rd      = r_rd;
    assign resp_err     = r_err;
    assign mem_enable   = r_enable;
    assign mem_rw       = r_rw;
    assign mem_addr     = r_addr;
    assign mem_din      = r_din;
    assign mem_size     = r_size;
    assign mem_sign_ext = r_sign_ext;

endmodule
